mem_io_sequencer: RTL and testbench

- Multi-cycle sequencer between the core's load/store stage and the shared data bus.
- Classifies each access as data-memory (BRAM) or memory-mapped I/O from address bits [31:10].
- Drives memory and I/O strobes, waits out BRAM read latency or the I/O acknowledge, and stalls the core until one response pulse is returned.
- Also produces the MemorIOtoReg-style writeback select for loads.

---
 rtl/mem_io_pkg.sv | 26 ++
 rtl/mem_io_addr_decode.sv | 26 ++
 rtl/mem_io_sequencer.sv | 178 +++++++++++++++++
 tb/tb_mem_io_sequencer.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_io_pkg.sv
// mem_io_pkg
//   Shared definitions for the load/store sequencer and the instruction
//   decoder: sequencer state encoding, default I/O window and BRAM address
//   width, and the load/store major opcodes.
package mem_io_pkg;

    // Sequencer state encoding, kept as plain constants so that legacy
    // decoder code can compare against them directly.
    typedef logic [1:0] seq_state_t;

    localparam seq_state_t ST_IDLE = 2'd0;
    localparam seq_state_t ST_MEM  = 2'd1;
    localparam seq_state_t ST_IO   = 2'd2;
    localparam seq_state_t ST_RESP = 2'd3;

    // addr[31:10] equal to this value selects memory-mapped I/O (top 1 KiB).
    localparam logic [21:0] IO_BASE_HI_DEFAULT = 22'h3FFFFF;

    // BRAM word-address width (addr[MEM_AW+1:2]).
    localparam int MEM_AW_DEFAULT = 14;

    // RV32 major opcodes, shared with the instruction decoder.
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

endpackage

// File: rtl/mem_io_addr_decode.sv
// mem_io_addr_decode
//   Combinational split of a byte address into the data-memory / I/O space
//   selector and the per-space addresses. Also used by the instruction
//   decoder to generate IORead/IOWrite.
// Ports:
//   addr     in  32      byte address
//   is_io    out 1       addr[31:10] hits the I/O window
//   mem_addr out MEM_AW  BRAM word address addr[MEM_AW+1:2]
//   io_addr  out 10      I/O register offset addr[9:0]
module mem_io_addr_decode
    import mem_io_pkg::*;
#(
    parameter int          MEM_AW     = MEM_AW_DEFAULT,
    parameter logic [21:0] IO_BASE_HI = IO_BASE_HI_DEFAULT
) (
    input  logic [31:0]       addr,
    output logic              is_io,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [9:0]        io_addr
);

    assign is_io    = (addr[31:10] == IO_BASE_HI);
    assign mem_addr = addr[MEM_AW+1:2];
    assign io_addr  = addr[9:0];

endmodule

// File: rtl/mem_io_sequencer.sv
// mem_io_sequencer
//   Multi-cycle sequencer between the load/store stage and the shared data
//   bus. Each accepted request goes either to BRAM (fixed read latency) or to
//   memory-mapped I/O (wait for io_ack, bounded by IO_TIMEOUT), and exactly
//   one rsp_valid pulse is returned. The core is stalled while busy.
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   req_valid/req_ready     request handshake (accept = valid & ready)
//   req_write, req_addr, req_wdata   request contents, sampled at accept
//   stall                   hold PC / pipeline register
//   rsp_valid, rsp_rdata    one-cycle completion pulse with load data
//   mem_or_io_to_reg        writeback select, high with rsp_valid for loads
//   err_timeout             high with rsp_valid when I/O never acknowledged
//   mem_en/we/addr/wdata/rdata       BRAM port
//   io_read/write/addr/wdata/rdata/ack  I/O bus
module mem_io_sequencer
    import mem_io_pkg::*;
#(
    parameter int          MEM_LAT    = 2,
    parameter logic [21:0] IO_BASE_HI = IO_BASE_HI_DEFAULT,
    parameter int          MEM_AW     = MEM_AW_DEFAULT,
    parameter int          IO_TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              req_ready,
    output logic              stall,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              mem_or_io_to_reg,
    output logic              err_timeout,
    output logic              mem_en,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              io_read,
    output logic              io_write,
    output logic [9:0]        io_addr,
    output logic [31:0]       io_wdata,
    input  logic [31:0]       io_rdata,
    input  logic              io_ack
);

    // +1 so the counters can hold the terminal values themselves.
    localparam int LAT_W = $clog2(MEM_LAT + 1);
    localparam int TO_W  = $clog2(IO_TIMEOUT + 1);

    seq_state_t        state;
    logic              wr_q;
    logic [LAT_W-1:0]  lat_cnt;
    logic [TO_W-1:0]   wait_cnt;

    logic              dec_is_io;
    logic [MEM_AW-1:0] dec_mem_addr;
    logic [9:0]        dec_io_addr;

    mem_io_addr_decode #(
        .MEM_AW     (MEM_AW),
        .IO_BASE_HI (IO_BASE_HI)
    ) u_addr_decode (
        .addr     (req_addr),
        .is_io    (dec_is_io),
        .mem_addr (dec_mem_addr),
        .io_addr  (dec_io_addr)
    );

    assign req_ready = (state == ST_IDLE);
    // Low in RESP so the core advances on the same cycle it sees rsp_valid.
    assign stall = (req_ready & req_valid) | (state == ST_MEM) | (state == ST_IO);

    // NOTE: every registered signal uses non-blocking assignment so all
    // next-state values are computed from this cycle's values; reset clears
    // them all, which also kills an in-flight strobe without a response.
    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= ST_IDLE;
            wr_q             <= 1'b0;
            lat_cnt          <= '0;
            wait_cnt         <= '0;
            rsp_valid        <= 1'b0;
            rsp_rdata        <= '0;
            mem_or_io_to_reg <= 1'b0;
            err_timeout      <= 1'b0;
            mem_en           <= 1'b0;
            mem_we           <= 1'b0;
            mem_addr         <= '0;
            mem_wdata        <= '0;
            io_read          <= 1'b0;
            io_write         <= 1'b0;
            io_addr          <= '0;
            io_wdata         <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        // Request fields are captured once here; later changes
                        // on the req_* inputs are ignored until the next accept.
                        wr_q      <= req_write;
                        mem_addr  <= dec_mem_addr;
                        mem_wdata <= req_wdata;
                        io_addr   <= dec_io_addr;
                        io_wdata  <= req_wdata;
                        lat_cnt   <= '0;
                        wait_cnt  <= '0;
                        if (dec_is_io) begin
                            io_read  <= ~req_write;
                            io_write <= req_write;
                            state    <= ST_IO;
                        end else begin
                            mem_en <= 1'b1;
                            mem_we <= req_write;
                            state  <= ST_MEM;
                        end
                    end
                end

                ST_MEM: begin
                    // BRAM enable is a single-cycle pulse on the first MEM cycle.
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    if (wr_q) begin
                        state            <= ST_RESP;
                        rsp_valid        <= 1'b1;
                        rsp_rdata        <= '0;
                        mem_or_io_to_reg <= 1'b0;
                    end else if (lat_cnt == LAT_W'(MEM_LAT)) begin
                        // lat_cnt is 0 in the enable cycle, so this is the
                        // cycle the BRAM data becomes valid.
                        state            <= ST_RESP;
                        rsp_valid        <= 1'b1;
                        rsp_rdata        <= mem_rdata;
                        mem_or_io_to_reg <= 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end

                ST_IO: begin
                    if (io_ack) begin
                        // Checked before the limit so a last-cycle ack wins.
                        io_read          <= 1'b0;
                        io_write         <= 1'b0;
                        state            <= ST_RESP;
                        rsp_valid        <= 1'b1;
                        rsp_rdata        <= wr_q ? '0 : io_rdata;
                        mem_or_io_to_reg <= ~wr_q;
                    end else if (wait_cnt == TO_W'(IO_TIMEOUT - 1)) begin
                        io_read          <= 1'b0;
                        io_write         <= 1'b0;
                        state            <= ST_RESP;
                        rsp_valid        <= 1'b1;
                        rsp_rdata        <= '0;
                        mem_or_io_to_reg <= ~wr_q;
                        err_timeout      <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                ST_RESP: begin
                    rsp_valid        <= 1'b0;
                    rsp_rdata        <= '0;
                    mem_or_io_to_reg <= 1'b0;
                    err_timeout      <= 1'b0;
                    state            <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_io_sequencer.sv
// tb_mem_io_sequencer
//   Scoreboard bench: each accepted request pushes its expected response
//   (data, flags, latency, strobe counts, addresses) and a negedge monitor
//   pops and compares on every rsp_valid. BRAM and I/O device are small
//   behavioural models driven by the DUT's own strobes.
module tb_mem_io_sequencer;

    localparam int MEM_LAT    = 2;
    localparam int MEM_AW     = 14;
    localparam int IO_TIMEOUT = 15;

    logic              clock = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_write;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              req_ready;
    logic              stall;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              mem_or_io_to_reg;
    logic              err_timeout;
    logic              mem_en;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              io_read;
    logic              io_write;
    logic [9:0]        io_addr;
    logic [31:0]       io_wdata;
    logic [31:0]       io_rdata;
    logic              io_ack;

    mem_io_sequencer #(
        .MEM_LAT    (MEM_LAT),
        .IO_BASE_HI (22'h3FFFFF),
        .MEM_AW     (MEM_AW),
        .IO_TIMEOUT (IO_TIMEOUT)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_write        (req_write),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .req_ready        (req_ready),
        .stall            (stall),
        .rsp_valid        (rsp_valid),
        .rsp_rdata        (rsp_rdata),
        .mem_or_io_to_reg (mem_or_io_to_reg),
        .err_timeout      (err_timeout),
        .mem_en           (mem_en),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_rdata        (mem_rdata),
        .io_read          (io_read),
        .io_write         (io_write),
        .io_addr          (io_addr),
        .io_wdata         (io_wdata),
        .io_rdata         (io_rdata),
        .io_ack           (io_ack)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- check bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- BRAM model: read data valid MEM_LAT cycles after mem_en ----------------
    bit [31:0] bram [1<<MEM_AW];
    logic [31:0] rd_d [MEM_LAT];
    bit          rd_v [MEM_LAT];

    always @(posedge clock) begin
        rd_v[0] <= mem_en && !mem_we;
        rd_d[0] <= bram[mem_addr];
        for (int i = 1; i < MEM_LAT; i++) begin
            rd_v[i] <= rd_v[i-1];
            rd_d[i] <= rd_d[i-1];
        end
        if (mem_en && mem_we) bram[mem_addr] = mem_wdata;
    end

    // Poisoned outside the valid cycle so early/late capture is visible.
    assign mem_rdata = rd_v[MEM_LAT-1] ? rd_d[MEM_LAT-1] : 32'hBAD0_0BAD;

    // ---------------- I/O device model: ack in the k-th strobe cycle (k=0: never) ----------------
    int          io_cfg_k    = 0;
    logic [31:0] io_cfg_data = '0;
    int          io_cyc      = 0;

    always @(posedge clock) io_cyc <= (io_read || io_write) ? io_cyc + 1 : 0;

    assign io_ack   = (io_read || io_write) && (io_cfg_k != 0) && (io_cyc == io_cfg_k - 1);
    assign io_rdata = io_ack ? io_cfg_data : 32'hBAD1_0BAD;

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] rdata;
        logic [31:0] to_reg;
        logic [31:0] err;
        int          lat;
        int          t0;
        int          n_en;
        int          n_we;
        int          n_rd;
        int          n_wr;
        logic [31:0] mem_addr;
        logic [31:0] io_addr;
        logic [31:0] wdata;
        bit          wr;
        bit          is_io;
    } exp_t;

    exp_t q[$];
    bit [31:0] ref_mem [1<<MEM_AW];

    // Per-transaction observations, cleared on each response and on reset.
    int          o_en, o_we, o_rd, o_wr, o_stall, o_en_cyc;
    logic [31:0] o_mem_addr, o_io_addr, o_wdata;

    task automatic clear_obs();
        o_en = 0; o_we = 0; o_rd = 0; o_wr = 0; o_stall = 0; o_en_cyc = 0;
        o_mem_addr = '0; o_io_addr = '0; o_wdata = '0;
    endtask

    always @(negedge clock) begin
        if (reset) begin
            clear_obs();
        end else begin
            check("excl_mem_io", 32'(mem_en & (io_read | io_write)), 0);
            check("excl_rd_wr", 32'(io_read & io_write), 0);
            if (q.size() > 0 && cyc > q[0].t0) check("ready_busy", 32'(req_ready), 0);

            if (stall) o_stall++;
            if (mem_en) begin
                o_en++;
                o_mem_addr = 32'(mem_addr);
                if (q.size() > 0) o_en_cyc = cyc - q[0].t0;
                if (mem_we) begin
                    o_we++;
                    o_wdata = mem_wdata;
                end
            end
            if (io_read) o_rd++;
            if (io_write) begin
                o_wr++;
                o_wdata = io_wdata;
            end
            if (io_read || io_write) o_io_addr = 32'(io_addr);

            if (rsp_valid) begin
                check("stall_in_resp", 32'(stall), 0);
                if (q.size() == 0) begin
                    check("rsp_unexpected", 32'(rsp_valid), 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("to_reg", 32'(mem_or_io_to_reg), e.to_reg);
                    check("err_timeout", 32'(err_timeout), e.err);
                    check("latency", cyc - e.t0, e.lat);
                    check("stall_cycles", o_stall, e.lat);
                    check("n_mem_en", o_en, e.n_en);
                    check("n_mem_we", o_we, e.n_we);
                    check("n_io_read", o_rd, e.n_rd);
                    check("n_io_write", o_wr, e.n_wr);
                    if (e.n_en > 0) begin
                        check("mem_addr", o_mem_addr, e.mem_addr);
                        check("mem_en_cycle", o_en_cyc, 1);
                    end
                    if (e.is_io) check("io_addr", o_io_addr, e.io_addr);
                    if (e.wr) check("wdata", o_wdata, e.wdata);
                end
                clear_obs();
            end else begin
                check("side_pulses", {30'd0, mem_or_io_to_reg, err_timeout}, 0);
            end
        end
    end

    // ---------------- driver ----------------
    // Called at posedge+#1; returns at posedge+#1 of the cycle after accept.
    task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input int k, input logic [31:0] io_data, input bit hold, output int t0);
        exp_t e;
        int   guard;
        int   widx;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        guard = 0;
        while (!req_ready && guard < 100) begin
            @(posedge clock); #1;
            guard++;
        end
        check("accept", 32'(req_ready), 1);
        io_cfg_k    = k;
        io_cfg_data = io_data;

        widx       = int'(addr[MEM_AW+1:2]);
        e.wr       = wr;
        e.is_io    = (addr[31:10] == 22'h3FFFFF);
        e.to_reg   = wr ? 0 : 1;
        e.wdata    = wdata;
        e.mem_addr = 32'(addr[MEM_AW+1:2]);
        e.io_addr  = 32'(addr[9:0]);
        e.n_en = 0; e.n_we = 0; e.n_rd = 0; e.n_wr = 0; e.err = 0;
        if (!e.is_io) begin
            // Cycles from the accept cycle T0 to the rsp_valid cycle.
            e.lat   = wr ? 2 : MEM_LAT + 2;
            e.n_en  = 1;
            e.n_we  = wr ? 1 : 0;
            e.rdata = wr ? 32'h0 : ref_mem[widx];
            if (wr) ref_mem[widx] = wdata;
        end else if (k >= 1 && k <= IO_TIMEOUT) begin
            e.lat   = k + 1;
            e.rdata = wr ? 32'h0 : io_data;
            if (wr) e.n_wr = k; else e.n_rd = k;
        end else begin
            e.lat   = IO_TIMEOUT + 1;
            e.rdata = 32'h0;
            e.err   = 1;
            if (wr) e.n_wr = IO_TIMEOUT; else e.n_rd = IO_TIMEOUT;
        end
        t0   = cyc;
        e.t0 = cyc;
        q.push_back(e);

        @(posedge clock); #1;
        // Scramble request fields: they must be ignored while busy.
        req_write = ~wr;
        req_addr  = $urandom;
        req_wdata = $urandom;
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (q.size() != 0 && guard < 100) begin
            @(posedge clock); #1;
            guard++;
        end
        check("rsp_arrived", q.size(), 0);
        q.delete();
        check("back_to_idle", 32'(req_ready), 1);
    endtask

    task automatic txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input int k, input logic [31:0] io_data);
        int t0;
        issue(wr, addr, wdata, k, io_data, 1'b0, t0);
        wait_idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int t0a, t0b;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_to_reg", 32'(mem_or_io_to_reg), 0);
        check("rst_err", 32'(err_timeout), 0);
        check("rst_mem_en", 32'(mem_en), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_io_read", 32'(io_read), 0);
        check("rst_io_write", 32'(io_write), 0);
        check("rst_io_addr", 32'(io_addr), 0);
        check("rst_io_wdata", io_wdata, 0);
        check("rst_req_ready", 32'(req_ready), 1);
        check("rst_stall", 32'(stall), 0);
        reset = 1'b0;
        @(posedge clock); #1;

        // Memory: seed, store/load pairs, low address bits ignored.
        txn(1'b1, 32'h0000_0000, 32'h1357_9BDF, 0, 0);
        txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 0);
        txn(1'b0, 32'h0000_0010, 32'h0, 0, 0);
        txn(1'b1, 32'h0000_0020, 32'h1234_5678, 0, 0);
        txn(1'b0, 32'h0000_0022, 32'h0, 0, 0);
        // Just below the I/O window is still memory.
        txn(1'b1, 32'hFFFF_F800, 32'h0F0F_0F0F, 0, 0);
        txn(1'b0, 32'hFFFF_F803, 32'h0, 0, 0);

        // I/O: ack on 3rd cycle, timeout, ack exactly at the limit, ack first cycle.
        txn(1'b0, 32'hFFFF_FC70, 32'h0, 3, 32'h0000_00A5);
        txn(1'b1, 32'hFFFF_FC00, 32'hCAFE_0001, 0, 0);
        txn(1'b0, 32'hFFFF_FD04, 32'h0, IO_TIMEOUT, 32'h5A5A_5A5A);
        txn(1'b1, 32'hFFFF_FFFC, 32'h8765_4321, 1, 0);
        txn(1'b0, 32'hFFFF_FC08, 32'h0, 0, 32'h1111_1111);

        // Reset in the 2nd IO cycle: strobe drops, no response, then normal service.
        issue(1'b0, 32'hFFFF_FC44, 32'h0, 0, 32'h0, 1'b0, t0a);
        @(posedge clock); #1;
        check("pre_rst_io_read", 32'(io_read), 1);
        reset = 1'b1;
        q.delete();
        @(posedge clock); #1;
        check("mid_rst_io_read", 32'(io_read), 0);
        check("mid_rst_io_addr", 32'(io_addr), 0);
        check("mid_rst_rsp", 32'(rsp_valid), 0);
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("post_rst_ready", 32'(req_ready), 1);
        txn(1'b0, 32'h0000_0000, 32'h0, 0, 0);

        // Back-to-back loads with req_valid held: second accept right after RESP.
        issue(1'b0, 32'h0000_0010, 32'h0, 0, 0, 1'b1, t0a);
        issue(1'b0, 32'h0000_0020, 32'h0, 0, 0, 1'b0, t0b);
        wait_idle();
        check("b2b_accept_gap", t0b - t0a, MEM_LAT + 3);

        // Mixed random traffic.
        for (int n = 0; n < 16; n++) begin
            int          kind;
            logic [31:0] a;
            kind = $urandom_range(0, 3);
            if (kind < 2) begin
                a = {24'h0, 2'b01, 4'($urandom), 2'($urandom)};
                txn(kind == 1, a, $urandom, 0, 0);
            end else begin
                a = {22'h3FFFFF, 10'($urandom)};
                txn(kind == 3, a, $urandom, $urandom_range(0, IO_TIMEOUT), $urandom);
            end
        end

        repeat (2) @(posedge clock);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
